// File: rtl/inverter_lane_scheduler_pkg.sv
// Shared definitions for the inverter lane scheduler: FSM state encoding and
// the lane-index width helper.
package inverter_lane_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_SELECT  = 3'd2,
        ST_DRIVE   = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    // Width of a lane index; never narrower than one bit.
    function automatic int lane_idx_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/inverter_lane_scheduler_slot_tick_gen.sv
// Slot tick generator: free-running 0..TICK_DIV-1 counter while enabled,
// with synchronous clear; tick marks the last count of each slot.
module slot_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at TICK_DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

endmodule

// File: rtl/inverter_lane_scheduler.sv
// Time-shares one external inverter across N_LANES switch lanes: round-robin
// over enabled lanes, drive, settle, capture into led, flag non-inverting results.
module inverter_lane_scheduler
    import inverter_lane_scheduler_pkg::*;
#(
    parameter int N_LANES  = 16,
    parameter int TICK_DIV = 100000,
    parameter int SETTLE   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_LANES-1:0]             sw,
    input  logic [N_LANES-1:0]             lane_en,
    input  logic                           run,
    output logic                           inv_a,
    input  logic                           inv_y,
    output logic [N_LANES-1:0]             led,
    output logic [lane_idx_w(N_LANES)-1:0] cur_lane,
    output logic                           busy,
    output logic                           sweep_done,
    output logic                           err
);
    localparam int LW  = lane_idx_w(N_LANES);
    localparam int DCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             state_q, state_d;
    logic [N_LANES-1:0] sw_meta_q, sw_meta_d;
    logic [N_LANES-1:0] sw_sync_q, sw_sync_d;
    logic [N_LANES-1:0] led_q, led_d;
    logic [LW-1:0]      ptr_q, ptr_d;
    logic [LW-1:0]      cur_lane_q, cur_lane_d;
    logic [DCW-1:0]     drive_cnt_q, drive_cnt_d;
    logic               inv_a_q, inv_a_d;
    logic               busy_q, busy_d;
    logic               sweep_done_q, sweep_done_d;
    logic               err_q, err_d;

    logic [LW-1:0]      cand_s;
    logic [LW-1:0]      sel_lane_s;
    logic               sel_found_s;
    logic [N_LANES-1:0] above_s;
    logic               higher_en_s;
    logic               tick_s;
    logic               tick_en_s;
    logic               tick_clr_s;

    slot_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en_s),
        .clr   (tick_clr_s),
        .tick  (tick_s)
    );

    // Two-stage synchroniser for the asynchronous switch inputs.
    always_comb begin
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
    end

    // First enabled lane at or after ptr (wrapping), and whether any lane above cur_lane is enabled.
    always_comb begin
        sel_found_s = 1'b0;
        sel_lane_s  = '0;
        cand_s      = '0;
        for (int k = 0; k < N_LANES; k++) begin
            cand_s = LW'((int'(ptr_q) + k) % N_LANES);
            if (!sel_found_s && lane_en[cand_s]) begin
                sel_found_s = 1'b1;
                sel_lane_s  = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        above_s     = ({N_LANES{1'b1}} << cur_lane_q) << 1'b1;
        higher_en_s = |(lane_en & above_s);
    end

    // FSM next state and all registered output next values.
    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        ptr_d        = ptr_q;
        cur_lane_d   = cur_lane_q;
        drive_cnt_d  = drive_cnt_q;
        inv_a_d      = inv_a_q;
        err_d        = err_q;
        sweep_done_d = 1'b0;
        tick_clr_s   = 1'b0;
        tick_en_s    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                inv_a_d = 1'b0;
                if (run && (|lane_en)) begin
                    state_d    = ST_WAIT;
                    err_d      = 1'b0;
                    tick_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tick_s) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SELECT: begin
                if (sel_found_s) begin
                    state_d     = ST_DRIVE;
                    cur_lane_d  = sel_lane_s;
                    inv_a_d     = sw_sync_q[sel_lane_s];
                    drive_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    inv_a_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (drive_cnt_q == DCW'(SETTLE - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    drive_cnt_d = drive_cnt_q + DCW'(1);
                end
            end
            ST_CAPTURE: begin
                led_d[cur_lane_q] = inv_y;
                if (inv_y == inv_a_q) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                ptr_d        = (cur_lane_q == LW'(N_LANES - 1)) ? '0 : cur_lane_q + LW'(1);
                sweep_done_d = !higher_en_s;
                if (run && (|lane_en)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    inv_a_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                inv_a_d = 1'b0;
            end
        endcase

        // Disabled lanes lose their led bit regardless of state, overriding a capture.
        led_d  = led_d & lane_en;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            led_q        <= '0;
            ptr_q        <= '0;
            cur_lane_q   <= '0;
            drive_cnt_q  <= '0;
            inv_a_q      <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            led_q        <= led_d;
            ptr_q        <= ptr_d;
            cur_lane_q   <= cur_lane_d;
            drive_cnt_q  <= drive_cnt_d;
            inv_a_q      <= inv_a_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
            err_q        <= err_d;
        end
    end

    assign inv_a      = inv_a_q;
    assign led        = led_q;
    assign cur_lane   = cur_lane_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inverter_lane_scheduler.sv
// Self-checking bench for inverter_lane_scheduler: slot-level reference model
// (served lane order, led image, err, sweep_done, timing) with random stimulus.
module tb_inverter_lane_scheduler;
    localparam int N_LANES  = 16;
    localparam int TICK_DIV = 4;
    localparam int SETTLE   = 2;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] sw      = 16'h0000;
    logic [15:0] lane_en = 16'h0000;
    logic        run     = 1'b0;
    logic        broken  = 1'b0;
    logic        inv_a;
    logic        inv_y;
    logic [15:0] led;
    logic [3:0]  cur_lane;
    logic        busy;
    logic        sweep_done;
    logic        err;

    logic [15:0] model_led = 16'h0000;
    logic [3:0]  model_ptr = 4'd0;
    logic        model_err = 1'b0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          first_sel;
    int          next_sel;

    inverter_lane_scheduler #(
        .N_LANES  (N_LANES),
        .TICK_DIV (TICK_DIV),
        .SETTLE   (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .lane_en    (lane_en),
        .run        (run),
        .inv_a      (inv_a),
        .inv_y      (inv_y),
        .led        (led),
        .cur_lane   (cur_lane),
        .busy       (busy),
        .sweep_done (sweep_done),
        .err        (err)
    );

    // Shared inverter: correct unless the broken flag makes it a buffer.
    assign inv_y = broken ? inv_a : ~inv_a;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    // Slot period: a tick landing in SELECT/DRIVE/CAPTURE is lost, so the next
    // usable tick is the first one at or after the cycle following CAPTURE.
    function automatic int slot_period();
        int p;
        p = TICK_DIV;
        while (p - 1 < SETTLE + 2) p = p + TICK_DIV;
        return p;
    endfunction

    // One clock; disabled lanes clear in the model as in the led rule.
    task automatic step();
        logic [15:0] en_prev;
        en_prev = lane_en;
        @(posedge clk);
        #1;
        model_led = model_led & en_prev;
    endtask

    task automatic apply_reset(input logic [15:0] sw_v, input logic [15:0] en_v,
                               input logic run_v, input logic broken_v);
        rst_n   = 1'b0;
        sw      = sw_v;
        lane_en = en_v;
        run     = run_v;
        broken  = broken_v;
        repeat (3) step();
        model_led = 16'h0000;
        model_ptr = 4'd0;
        model_err = 1'b0;
        n_checks++;
        if (led !== 16'h0000 || inv_a !== 1'b0 || cur_lane !== 4'd0 || busy !== 1'b0 ||
            sweep_done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: led=%h inv_a=%b cur_lane=%0d busy=%b sweep_done=%b err=%b, expected all 0",
                     led, inv_a, cur_lane, busy, sweep_done, err);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy: busy=%b err=%b, expected busy=1 err=0", busy, err);
        end
    endtask

    // Serve one slot against the model; optionally change lane_en/run after step chg_at.
    task automatic slot(input int to_sel, input int chg_at, input logic [15:0] chg_en,
                        input logic chg_run, output logic [3:0] li);
        logic [15:0] en_sel;
        logic        a_exp;
        logic        exp_sweep;
        logic        exp_busy;
        logic        found;
        for (int i = 0; i < to_sel; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b1 || sweep_done !== 1'b0 || led !== model_led || err !== model_err) begin
                n_fail++;
                $display("FAIL wait_phase: busy=%b sweep_done=%b led=%h err=%b, expected busy=1 sweep_done=0 led=%h err=%b",
                         busy, sweep_done, led, err, model_led, model_err);
            end
        end
        en_sel = lane_en;
        found  = 1'b0;
        li     = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (!found && en_sel[4'((int'(model_ptr) + k) % 16)]) begin
                found = 1'b1;
                li    = 4'((int'(model_ptr) + k) % 16);
            end
        end
        a_exp = sw[li];
        for (int j = 1; j <= SETTLE + 2; j++) begin
            exp_sweep = 1'b0;
            exp_busy  = 1'b1;
            if (j == SETTLE + 2) begin
                model_led[li] = broken ? a_exp : ~a_exp;
                if (broken) model_err = 1'b1;
                exp_sweep = ((lane_en >> (li + 5'd1)) == 16'h0000);
                exp_busy  = run && (lane_en != 16'h0000);
                model_ptr = li + 4'd1;
            end
            step();
            n_checks++;
            if (led !== model_led || busy !== exp_busy || sweep_done !== exp_sweep || err !== model_err) begin
                n_fail++;
                $display("FAIL slot_step lane %0d step %0d: led=%h busy=%b sweep_done=%b err=%b, expected led=%h busy=%b sweep_done=%b err=%b",
                         li, j, led, busy, sweep_done, err, model_led, exp_busy, exp_sweep, model_err);
            end
            if (j <= SETTLE + 1) begin
                n_checks++;
                if (cur_lane !== li || inv_a !== a_exp) begin
                    n_fail++;
                    $display("FAIL slot_drive step %0d: cur_lane=%0d inv_a=%b, expected cur_lane=%0d inv_a=%b",
                             j, cur_lane, inv_a, li, a_exp);
                end
            end
            if (j == chg_at) begin
                lane_en = chg_en;
                run     = chg_run;
            end
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || inv_a !== 1'b0 || sweep_done !== 1'b0 || led !== model_led || err !== model_err) begin
                n_fail++;
                $display("FAIL idle: busy=%b inv_a=%b sweep_done=%b led=%h err=%b, expected busy=0 inv_a=0 sweep_done=0 led=%h err=%b",
                         busy, inv_a, sweep_done, led, err, model_led, model_err);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    endtask

    task automatic test_full_sweep();
        logic [3:0] li;
        apply_reset(16'h00FF, 16'hFFFF, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            slot((i == 0) ? first_sel : next_sel, 0, 16'h0000, 1'b0, li);
            n_checks++;
            if (li !== 4'(i)) begin
                n_fail++;
                $display("FAIL sweep_order: model lane %0d, expected %0d", li, i);
            end
        end
        n_checks++;
        if (led !== 16'hFF00 || cur_lane !== 4'd15 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_result: led=%h cur_lane=%0d err=%b, expected led=ff00 cur_lane=15 err=0",
                     led, cur_lane, err);
        end
    endtask

    task automatic test_sparse();
        logic [3:0] li;
        apply_reset(16'h0001, 16'h0005, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            slot((i == 0) ? first_sel : next_sel, 0, 16'h0000, 1'b0, li);
            n_checks++;
            if (cur_lane !== 4'((i % 2) * 2)) begin
                n_fail++;
                $display("FAIL sparse_order: cur_lane=%0d, expected %0d", cur_lane, (i % 2) * 2);
            end
        end
        n_checks++;
        if (led !== 16'h0004) begin
            n_fail++;
            $display("FAIL sparse_led: led=%h, expected 0004", led);
        end
    endtask

    task automatic test_broken();
        logic [3:0] li;
        apply_reset(16'($urandom), 16'hFFFF, 1'b1, 1'b1);
        slot(first_sel, 0, 16'h0000, 1'b0, li);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL broken_err: err=%b, expected 1", err);
        end
        slot(next_sel, 0, 16'h0000, 1'b0, li);
        slot(next_sel, 1, 16'hFFFF, 1'b0, li);
        idle_steps(3);
        broken = 1'b0;
        run    = 1'b1;
        step();
        model_err = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: err=%b busy=%b, expected err=0 busy=1", err, busy);
        end
        slot(first_sel, 0, 16'h0000, 1'b0, li);
    endtask

    task automatic test_run_drop();
        logic [3:0]  li;
        logic [15:0] sw_v;
        sw_v = 16'($urandom);
        apply_reset(sw_v, 16'hFFFF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) slot((i == 0) ? first_sel : next_sel, 0, 16'h0000, 1'b0, li);
        slot(next_sel, 1, 16'hFFFF, 1'b0, li);
        idle_steps(4);
        n_checks++;
        if (led[5] !== ~sw_v[5] || cur_lane !== 4'd5) begin
            n_fail++;
            $display("FAIL run_drop: led[5]=%b cur_lane=%0d, expected led[5]=%b cur_lane=5", led[5], cur_lane, ~sw_v[5]);
        end
    endtask

    task automatic test_lane_clear();
        logic [3:0] li;
        apply_reset(16'($urandom) & 16'hFFF7, 16'hFFFF, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) slot((i == 0) ? first_sel : next_sel, 0, 16'h0000, 1'b0, li);
        slot(next_sel, 0, 16'h0000, 1'b0, li);
        slot(next_sel, 1, 16'hFFF7, 1'b1, li);
        n_checks++;
        if (led[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL lane3_clear: led[3]=%b, expected 0", led[3]);
        end
        slot(next_sel, 0, 16'h0000, 1'b0, li);
        slot(next_sel, 1, 16'h0000, 1'b1, li);
        n_checks++;
        if (li !== 4'd4) begin
            n_fail++;
            $display("FAIL lane3_skip: served lane %0d, expected 4", li);
        end
        idle_steps(3);
        n_checks++;
        if (led !== 16'h0000) begin
            n_fail++;
            $display("FAIL all_disabled_led: led=%h, expected 0000", led);
        end
    endtask

    task automatic test_random();
        logic [3:0]  li;
        logic [15:0] en_v;
        logic [15:0] new_en;
        int          chg;
        do en_v = 16'($urandom); while (en_v == 16'h0000);
        apply_reset(16'($urandom), en_v, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            chg = 0;
            do new_en = 16'($urandom); while (new_en == 16'h0000);
            if ($urandom_range(0, 9) < 3) chg = $urandom_range(1, SETTLE + 1);
            slot((i == 0) ? first_sel : next_sel, chg, new_en, 1'b1, li);
            sw = 16'($urandom);
        end
    endtask

    initial begin
        first_sel = TICK_DIV;
        next_sel  = slot_period() - (SETTLE + 2);
        test_reset();
        test_full_sweep();
        test_sparse();
        test_broken();
        test_run_drop();
        test_lane_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
